// File: rtl/alu_pkg.sv
// Shared opcode map, sequencer state type and opcode legality helper
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_LAST = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  output logic [DATA_W-1:0]        rdata_a_o,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [DATA_W-1:0]        rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command-side controller for the 8-bit ALU: fetches operands from the
// register file, holds ALU inputs while the result settles, writes back and responds.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned NREGS         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_dst,
  input  logic [$clog2(NREGS)-1:0] cmd_srca,
  input  logic [$clog2(NREGS)-1:0] cmd_srcb,
  input  logic                     cmd_useimm,
  input  logic [DATA_W-1:0]        cmd_imm,
  output logic [DATA_W-1:0]        alu_operanda,
  output logic [DATA_W-1:0]        alu_operandb,
  output logic [3:0]               alu_mux,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [3:0]        op_q, op_d;
  logic [IDX_W-1:0]  dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic              rf_we;
  logic              capture;
  logic              div_zero;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (dst_q),
    .wdata_i   (alu_result),
    .raddr_a_i (cmd_srca),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_srcb),
    .rdata_b_o (rf_rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Operand/opcode registers only change on a legal accept, so the ALU
  // inputs hold their last issued values in every other state.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    op_d       = op_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (is_legal_op(cmd_op)) begin
            opa_d   = rf_rdata_a;
            opb_d   = cmd_useimm ? cmd_imm : rf_rdata_b;
            op_d    = cmd_op;
            dst_d   = cmd_dst;
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = ISSUE;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESPOND;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (capture) begin
          rsp_data_d = div_zero ? '1 : alu_result;
          rsp_err_d  = div_zero;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESPOND);
    capture   = (state_q == ISSUE) && (cnt_q == CNT_W'(1));
    div_zero  = (op_q == OP_DIV) && (opb_q == '0);
    rf_we     = capture && !div_zero;
  end

  assign alu_operanda = opa_q;
  assign alu_operandb = opb_q;
  assign alu_mux      = op_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side controller for the 8-bit combinational ALU (opcode 0x0–0xB: ADD, SUB, MUL, DIV, NOT, AND, OR, NAND, NOR, XOR, SHL1, SHR1).
- Accepts register-file commands over a valid/ready interface and drives the ALU operand/opcode inputs from registers.
- Captures the ALU result, writes it back to a small register file and returns it on a valid/ready response channel.
- Sits between a host/test master and the ALU instance.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
NREGS, 4, register-file depth; index width is clog2(NREGS).
SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before the result is captured; minimum 1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  4  ALU opcode.
cmd_dst  in  clog2(NREGS)  destination register.
cmd_srca  in  clog2(NREGS)  operand A register.
cmd_srcb  in  clog2(NREGS)  operand B register.
cmd_useimm  in  1  operand B taken from cmd_imm instead of cmd_srcb.
cmd_imm  in  DATA_W  immediate operand B.
alu_operanda  out  DATA_W  to ALU operand A.
alu_operandb  out  DATA_W  to ALU operand B.
alu_mux  out  4  to ALU opcode select.
alu_result  in  DATA_W  from ALU result.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  DATA_W  result value.
rsp_err  out  1  command failed (illegal opcode or divide by zero).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alu_operanda/alu_operandb/alu_mux=0, all registers=0, settle counter=0.
- cmd_ready=1 only in IDLE. rsp_valid=1 only in RESPOND.
- FSM states: IDLE, ISSUE, RESPOND.
- IDLE, accept on cmd_valid&cmd_ready (edge ending cycle T):
  - Legal op (0x0–0xB): register opA=reg[srca], opB=useimm?imm:reg[srcb], op and dst; load settle counter with SETTLE_CYCLES; go to ISSUE.
  - Illegal op (0xC–0xF): no ALU issue, ALU outputs unchanged, no writeback; rsp_data=0x00, rsp_err=1; go to RESPOND.
- ISSUE:
  - ALU outputs driven from registered operands starting T+1, held constant.
  - Counter decrements each cycle. At the edge where it reaches 0 (end of cycle T+SETTLE_CYCLES), capture alu_result.
  - Normal capture: reg[dst]=alu_result, rsp_data=alu_result, rsp_err=0.
  - Divide by zero (op 0x3 and opB=0): no writeback, rsp_data=0xFF, rsp_err=1.
  - Go to RESPOND.
- RESPOND: rsp_valid, rsp_data and rsp_err are held stable until rsp_ready. On handshake go to IDLE; cmd_ready=1 the next cycle.
- Latency: response valid in cycle T+1+SETTLE_CYCLES. Back-to-back throughput with rsp_ready=1 is one command per 2+SETTLE_CYCLES cycles.
- ALU outputs keep their last issued values outside ISSUE (no glitching to 0).
- Width: the ALU truncates to DATA_W (MUL low byte, SUB wraps mod 256). The sequencer passes alu_result unmodified.
- Hazards: writeback completes before the next accept, so srca/srcb==previous dst reads the new value. srca==srcb==dst is legal.
- cmd_* inputs are ignored outside IDLE.
- rst_n asserted mid-operation: immediate return to reset values, register file cleared, pending response dropped.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD=0x0 … OP_SHR=0xB, OP_LAST=0xB.
  - State enum (IDLE, ISSUE, RESPOND).
  - Function is_legal_op.
- Sub-module alu_regfile: NREGS×DATA_W, two combinational read ports, one synchronous write port, async active-low clear.

Test Plan:
- Reset, then cmd ADD dst=1 srca=0 useimm imm=0x05 (ALU stub real) -> rsp_data=0x05, err=0, rsp_valid in cycle T+2, reg1=0x05.
- SUB dst=2 srca=0 srcb=1 (reg0=0x00, reg1=0x05) -> rsp_data=0xFB (wrap), reg2=0xFB. Then MUL reg2×imm 0x02 -> 0xF6.
- DIV srca=1 useimm imm=0x00 -> rsp_data=0xFF, err=1, reg[dst] unchanged. Then op=0xD -> rsp_data=0x00, err=1, alu_mux unchanged.
- rsp_ready low 5 cycles during RESPOND -> rsp_* stable and cmd_ready=0 throughout. With rsp_ready=1, 4 ADD commands -> accepts every 3 cycles (SETTLE_CYCLES=1).
- Chained RAW: ADD r1=r1+imm 0x01 issued 3 times back-to-back from 0 -> responses 0x01, 0x02, 0x03.
- rst_n pulsed low during ISSUE -> rsp_valid=0, cmd_ready=1, all regs=0, ALU outputs=0 asynchronously; next command behaves normally.
